// File: rtl/frame_writer_1_a.sv
// Write-side address generator for frame buffer RAM1 port A.
// Captures one SOF-aligned frame per arm request into addresses 0..FRAME_PIXELS-1.
module frame_writer_1_a #(
    parameter int unsigned ADDR_W       = 18,
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned FRAME_PIXELS = 153600
) (
    input  logic              clk,
    input  logic              Reset_Main,
    input  logic              arm,
    input  logic              pix_valid,
    input  logic              pix_sof,
    input  logic [DATA_W-1:0] pix_data,
    output logic [ADDR_W-1:0] addr_1a,
    output logic [DATA_W-1:0] din_1a,
    output logic              we_1a,
    output logic              busy,
    output logic              frame_done,
    output logic              sync_err
);

    typedef enum logic [1:0] {
        StIdle,
        StWaitSof,
        StWrite
    } state_e;

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(FRAME_PIXELS - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic              we_q, we_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;

    always_ff @(posedge clk or posedge Reset_Main) begin
        if (Reset_Main) begin
            state_q <= StIdle;
            count_q <= '0;
            addr_q  <= '0;
            din_q   <= '0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            we_q    <= we_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        addr_d  = addr_q;
        din_d   = din_q;
        we_d    = 1'b0;
        done_d  = 1'b0;
        err_d   = err_q;

        unique case (state_q)
            StIdle: begin
                if (arm) begin
                    state_d = StWaitSof;
                    err_d   = 1'b0;
                end
            end
            StWaitSof: begin
                if (pix_valid && pix_sof) begin
                    we_d    = 1'b1;
                    addr_d  = '0;
                    din_d   = pix_data;
                    count_d = ADDR_W'(1);
                    state_d = StWrite;
                end
            end
            StWrite: begin
                if (pix_valid) begin
                    we_d  = 1'b1;
                    din_d = pix_data;
                    if (pix_sof) begin
                        // Early SOF restarts the frame, even on the final slot.
                        err_d   = 1'b1;
                        addr_d  = '0;
                        count_d = ADDR_W'(1);
                    end else begin
                        addr_d = count_q;
                        if (count_q == LastAddr) begin
                            done_d  = 1'b1;
                            count_d = '0;
                            state_d = StIdle;
                        end else begin
                            count_d = count_q + ADDR_W'(1);
                        end
                    end
                end
            end
            default: begin
                state_d = StIdle;
                count_d = '0;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    assign addr_1a    = addr_q;
    assign din_1a     = din_q;
    assign we_1a      = we_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign sync_err   = err_q;

endmodule

// File: tb/tb_frame_writer_1_a.sv
// Randomized scoreboard bench for frame_writer_1_a with a small frame size.
// Expected writes are queued by a frame-level model; a monitor checks each we_1a.
module tb_frame_writer_1_a;

    localparam int unsigned ADDR_W = 18;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned FP     = 16;

    logic              clk;
    logic              Reset_Main;
    logic              arm;
    logic              pix_valid;
    logic              pix_sof;
    logic [DATA_W-1:0] pix_data;
    logic [ADDR_W-1:0] addr_1a;
    logic [DATA_W-1:0] din_1a;
    logic              we_1a;
    logic              busy;
    logic              frame_done;
    logic              sync_err;

    frame_writer_1_a #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .FRAME_PIXELS(FP)
    ) dut (
        .clk       (clk),
        .Reset_Main(Reset_Main),
        .arm       (arm),
        .pix_valid (pix_valid),
        .pix_sof   (pix_sof),
        .pix_data  (pix_data),
        .addr_1a   (addr_1a),
        .din_1a    (din_1a),
        .we_1a     (we_1a),
        .busy      (busy),
        .frame_done(frame_done),
        .sync_err  (sync_err)
    );

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              done;
    } wr_t;

    wr_t exp_q[$];
    int  n_vec = 0;
    int  n_err = 0;
    bit  started = 0;

    // Frame-level reference: is a capture pending, has SOF been seen, pixel position.
    bit  m_capturing;
    bit  m_in_frame;
    int  m_pos;
    bit  m_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_clear();
        m_capturing = 0;
        m_in_frame  = 0;
        m_pos       = 0;
        m_err       = 0;
    endfunction

    function automatic void model_step(bit a, bit v, bit s, logic [DATA_W-1:0] d);
        wr_t w;
        if (!m_capturing) begin
            if (a) begin
                m_capturing = 1;
                m_in_frame  = 0;
                m_err       = 0;
            end
            return;
        end
        if (!v) return;
        if (s) begin
            if (m_in_frame) m_err = 1;
            m_in_frame = 1;
            m_pos      = 0;
        end else if (!m_in_frame) begin
            return;
        end
        w.addr = ADDR_W'(m_pos);
        w.data = d;
        w.done = (m_pos == FP - 1);
        exp_q.push_back(w);
        m_pos = m_pos + 1;
        if (m_pos == FP) begin
            m_capturing = 0;
            m_in_frame  = 0;
        end
    endfunction

    task automatic cyc(bit a, bit v, bit s, logic [DATA_W-1:0] d);
        @(negedge clk);
        n_vec++;
        if (busy !== m_capturing || sync_err !== m_err) begin
            n_err++;
            $display("FAIL status busy/sync_err got=%b/%b want=%b/%b t=%0t",
                     busy, sync_err, m_capturing, m_err, $time);
        end
        arm       = a;
        pix_valid = v;
        pix_sof   = s;
        pix_data  = d;
        model_step(a, v, s, d);
    endtask

    task automatic check_zero(string tag);
        n_vec++;
        if ({addr_1a, din_1a, we_1a, busy, frame_done, sync_err} !== '0) begin
            n_err++;
            $display("FAIL %s outputs got addr=%0d din=%0h we=%b busy=%b done=%b err=%b want all 0",
                     tag, addr_1a, din_1a, we_1a, busy, frame_done, sync_err);
        end
    endtask

    task automatic do_reset(string tag);
        Reset_Main = 1'b1;
        model_clear();
        exp_q.delete();
        #1;
        check_zero(tag);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            pix_valid = ~pix_valid;
            pix_sof   = 1'b1;
            arm       = 1'b1;
            check_zero(tag);
        end
        @(negedge clk);
        Reset_Main = 1'b0;
        arm        = 1'b0;
        pix_valid  = 1'b0;
        pix_sof    = 1'b0;
    endtask

    // Monitor: compare every write strobe with the head of the scoreboard.
    initial begin
        wr_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!started || Reset_Main) continue;
            if (we_1a === 1'b1) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_write got addr=%0d din=%0h want no write",
                             addr_1a, din_1a);
                end else begin
                    e = exp_q.pop_front();
                    if (addr_1a !== e.addr || din_1a !== e.data || frame_done !== e.done) begin
                        n_err++;
                        $display("FAIL write got addr=%0d din=%0h done=%b want addr=%0d din=%0h done=%b",
                                 addr_1a, din_1a, frame_done, e.addr, e.data, e.done);
                    end
                end
            end else if (frame_done !== 1'b0) begin
                n_vec++;
                n_err++;
                $display("FAIL stray_done got frame_done=%b want 0 (no write)", frame_done);
            end
        end
    end

    initial begin
        arm        = 1'b0;
        pix_valid  = 1'b0;
        pix_sof    = 1'b0;
        pix_data   = '0;
        Reset_Main = 1'b1;
        started    = 1;
        do_reset("reset");
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, '0);

        // Pixels in IDLE and pre-SOF pixels are dropped; arm mid-frame ignored.
        for (int i = 0; i < 5; i++) cyc(0, 1, i == 2, DATA_W'(100 + i));
        cyc(1, 0, 0, '0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, DATA_W'(200 + i));
        for (int i = 0; i < FP; i++) cyc(i == 5, 1, i == 0, DATA_W'(i));

        // Arm immediately after frame_done, then a gapped stream.
        cyc(1, 0, 0, '0);
        cyc(0, 1, 1, 16'hA000);
        for (int i = 1; i < FP; i++) begin
            cyc(0, 0, 0, 16'hDEAD);
            cyc(0, 1, 0, DATA_W'(16'hA000 + i));
        end
        cyc(0, 0, 0, '0);

        // Early SOF at index 6 restarts the frame and sets sync_err.
        cyc(1, 0, 0, '0);
        for (int i = 0; i < 6; i++) cyc(0, 1, i == 0, DATA_W'(16'hB000 + i));
        cyc(0, 1, 1, 16'hC000);
        for (int i = 1; i < FP; i++) cyc(0, 1, 0, DATA_W'(16'hC000 + i));
        cyc(0, 0, 0, '0);
        cyc(1, 0, 0, '0);
        cyc(0, 0, 0, '0);

        // SOF on the final slot counts as a restart, no frame_done.
        for (int i = 0; i < FP; i++) cyc(0, 1, i == 0 || i == FP - 1, DATA_W'(16'hD000 + i));
        for (int i = 1; i < FP; i++) cyc(0, 1, 0, DATA_W'(16'hE000 + i));

        // Mid-frame reset while address 9 is being written.
        cyc(1, 0, 0, '0);
        for (int i = 0; i < 10; i++) cyc(0, 1, i == 0, DATA_W'(16'hF000 + i));
        @(posedge clk);
        #3;
        do_reset("mid_reset");
        cyc(1, 0, 0, '0);
        for (int i = 0; i < 4; i++) cyc(0, 1, i == 0, DATA_W'(16'h1200 + i));

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            cyc($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 19) == 0, DATA_W'($urandom));
        end
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, '0);

        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain got %0d pending writes want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/frame_writer_1_a.md
# frame_writer_1_a

Write-side address generator for frame buffer RAM1, port A. It captures one frame of incoming pixels per `arm` request. Starting at the pixel flagged start-of-frame, it writes the frame into RAM1 at linear addresses 0..FRAME_PIXELS-1, then reports completion. It is the producer counterpart of the display-side read address generator on port B, which scans the same 0..153599 address range while VtcVde is high.

## Interface
- `ADDR_W`, 18, RAM1 address width; requires FRAME_PIXELS <= 2^ADDR_W
- `DATA_W`, 16, pixel / RAM1 data width
- `FRAME_PIXELS`, 153600, pixels per frame; last address is FRAME_PIXELS-1 (153599)
- `clk`  in  1  system clock; all logic on posedge
- `Reset_Main`  in  1  asynchronous, active-high reset
- `arm`  in  1  single-cycle request to capture the next frame
- `pix_valid`  in  1  pixel qualifier; one pixel per cycle when high
- `pix_sof`  in  1  first pixel of a frame; meaningful only with pix_valid
- `pix_data`  in  DATA_W  pixel value
- `addr_1a`  out  ADDR_W  RAM1 port A write address
- `din_1a`  out  DATA_W  RAM1 port A write data
- `we_1a`  out  1  RAM1 port A write enable
- `busy`  out  1  high in WAIT_SOF and WRITE
- `frame_done`  out  1  one-cycle pulse on the last write of a frame
- `sync_err`  out  1  sticky flag: early SOF seen during WRITE

## Operation
- Reset (asynchronous, immediate): state IDLE, internal count 0. addr_1a=0, din_1a=0, we_1a=0, busy=0, frame_done=0, sync_err=0.
- Accepted pixel: one cycle where pix_valid=1, and either state is WAIT_SOF with pix_sof=1, or state is WRITE.
- IDLE:
  - arm=1 -> WAIT_SOF and clear sync_err.
  - Pixels are ignored.
- WAIT_SOF:
  - pix_valid & pix_sof -> write the pixel to address 0, set count=1, go to WRITE.
  - Valid pixels without SOF are dropped.
- WRITE, normal pixel (pix_valid & !pix_sof):
  - Write to address=count, then increment count.
  - If the address written equals FRAME_PIXELS-1: assert frame_done with that write and go to IDLE.
- WRITE, early SOF (pix_valid & pix_sof): set sync_err, write the pixel to address 0, set count=1, stay in WRITE. The frame restarts, so completion needs FRAME_PIXELS pixels from the new SOF.
- An SOF on the final pixel slot also counts as an early SOF and restarts the frame; no frame_done is issued.
- `arm` outside IDLE is ignored and not queued.
- Count never exceeds FRAME_PIXELS-1, so no wrap-around occurs inside the ADDR_W-bit counter.
- pix_data is passed to din_1a unmodified.
- Only one frame is captured per arm. A new capture needs a new arm.

## Timing
- All outputs are registered.
- A pixel accepted at edge N drives we_1a=1 with matching addr_1a/din_1a during cycle N..N+1.
- Pipeline: one cycle of latency, throughput of one pixel per cycle. Back-to-back pixels give continuous we_1a.
- we_1a is high for exactly one cycle per accepted pixel and low otherwise. addr_1a and din_1a hold their last values while we_1a=0.
- frame_done is high in the same cycle as the last we_1a, for exactly one cycle.
- busy falls at that same edge.
- An arm sampled in the cycle after frame_done is accepted.
- busy rises at the edge that samples arm.
- sync_err rises with the restart write and holds until the next accepted arm or Reset_Main.
- Reset_Main mid-frame: all outputs drop asynchronously and the partial frame is abandoned. The next capture starts at address 0 after a new arm.

## Test plan
- Reset: assert Reset_Main with pix_valid toggling -> all outputs 0. Deassert with arm=0 -> no we_1a.
- Full frame (default parameters): arm, then SOF plus 153600 contiguous pixels with data=index.
  - Expect we_1a on 153600 consecutive cycles, addr 0..153599, din=addr.
  - Expect frame_done only with addr 153599, then busy=0.
- Gapped stream (FRAME_PIXELS=16): pix_valid alternating 1/0 -> we_1a pulses only for valid pixels, addresses 0..15 without skips, frame_done on the 16th write.
- Ignore rules (FRAME_PIXELS=16):
  - 5 valid pixels in IDLE, then arm, then 3 non-SOF pixels -> no writes.
  - An SOF is then accepted at address 0.
  - arm pulsed mid-frame has no effect.
- Early SOF (FRAME_PIXELS=16):
  - SOF at pixel index 6 -> sync_err=1 and the write lands at address 0.
  - 15 more pixels complete the frame with frame_done.
  - The next arm clears sync_err.
- Mid-frame reset: Reset_Main at address 9 -> we_1a low in the same cycle. Then arm plus SOF -> first write at address 0, and sync_err=0.
